// File: rtl/alu_muldiv_seq.sv
// alu_muldiv_seq: multi-cycle unsigned 16x16 multiply (low half) and 16/16 divide sequencer
// that drives an external combinational 16-bit ALU one shift-add / shift-subtract step per cycle.
//
// Optional feature macro: ALU_SEQ_EARLY_EXIT_EN
//   defined   -> MUL finishes once the remaining multiplier bits are all zero
//   undefined -> MUL always runs 16 iterations
//
// Ports:
//   i_clk, i_rst_n         clock, asynchronous active-low reset
//   i_start, i_op          job request (sampled when o_ready), 0=MUL 1=DIVU
//   i_a, i_b               multiplicand/dividend, multiplier/divisor
//   o_ready, o_busy        IDLE indicator, RUN/DONE indicator
//   o_done                 one-cycle completion pulse
//   o_result, o_rem, o_dz  product low/quotient, remainder, divide-by-zero flag
//   o_alu_opcode/wordA/B   ALU drive (ADD=0, SUB=1), zero outside RUN
//   i_alu_result/carry     ALU result and borrow (SUB)

module alu_muldiv_seq (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic        i_start,
  input  logic        i_op,
  input  logic [15:0] i_a,
  input  logic [15:0] i_b,
  output logic        o_ready,
  output logic        o_busy,
  output logic        o_done,
  output logic [15:0] o_result,
  output logic [15:0] o_rem,
  output logic        o_dz,
  output logic [3:0]  o_alu_opcode,
  output logic [15:0] o_alu_wordA,
  output logic [15:0] o_alu_wordB,
  input  logic [15:0] i_alu_result,
  input  logic        i_alu_carry
);

  localparam logic [3:0] OpcAdd = 4'h0;
  localparam logic [3:0] OpcSub = 4'h1;

  typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

  state_e      state_q, state_d;
  logic        op_q, op_d;
  logic [15:0] divisor_q, divisor_d;
  logic [15:0] mcand_q, mcand_d;
  logic [15:0] mplier_q, mplier_d;
  logic [15:0] acc_q, acc_d;
  logic [15:0] dividend_q, dividend_d;
  logic [15:0] rem_q, rem_d;
  logic [15:0] quot_q, quot_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [15:0] result_q, result_d;
  logic [15:0] rem_out_q, rem_out_d;
  logic        dz_q, dz_d;

  logic [15:0] div_t;
  logic [15:0] mplier_shr;
  logic [15:0] acc_new;
  logic [15:0] rem_new;
  logic [15:0] quot_new;
  logic        last_iter;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q    <= StIdle;
      op_q       <= 1'b0;
      divisor_q  <= '0;
      mcand_q    <= '0;
      mplier_q   <= '0;
      acc_q      <= '0;
      dividend_q <= '0;
      rem_q      <= '0;
      quot_q     <= '0;
      cnt_q      <= '0;
      result_q   <= '0;
      rem_out_q  <= '0;
      dz_q       <= 1'b0;
    end else begin
      state_q    <= state_d;
      op_q       <= op_d;
      divisor_q  <= divisor_d;
      mcand_q    <= mcand_d;
      mplier_q   <= mplier_d;
      acc_q      <= acc_d;
      dividend_q <= dividend_d;
      rem_q      <= rem_d;
      quot_q     <= quot_d;
      cnt_q      <= cnt_d;
      result_q   <= result_d;
      rem_out_q  <= rem_out_d;
      dz_q       <= dz_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    op_d         = op_q;
    divisor_d    = divisor_q;
    mcand_d      = mcand_q;
    mplier_d     = mplier_q;
    acc_d        = acc_q;
    dividend_d   = dividend_q;
    rem_d        = rem_q;
    quot_d       = quot_q;
    cnt_d        = cnt_q;
    result_d     = result_q;
    rem_out_d    = rem_out_q;
    dz_d         = dz_q;
    o_alu_opcode = OpcAdd;
    o_alu_wordA  = '0;
    o_alu_wordB  = '0;

    // Partial remainder with the next dividend bit shifted in.
    div_t      = {rem_q[14:0], dividend_q[15]};
    mplier_shr = mplier_q >> 1;
    acc_new    = mplier_q[0] ? i_alu_result : acc_q;
    // Borrow means t < divisor: keep t and shift in a 0 quotient bit.
    rem_new    = i_alu_carry ? div_t : i_alu_result;
    quot_new   = {quot_q[14:0], ~i_alu_carry};
    last_iter  = (cnt_q == 4'd15);

    unique case (state_q)
      StIdle: begin
        if (i_start) begin
          op_d      = i_op;
          divisor_d = i_b;
          cnt_d     = '0;
          dz_d      = 1'b0;
          if (i_op) begin
            dividend_d = i_a;
            rem_d      = '0;
            quot_d     = '0;
            if (i_b == 16'd0) begin
              state_d   = StDone;
              result_d  = 16'hFFFF;
              rem_out_d = i_a;
              dz_d      = 1'b1;
            end else begin
              state_d = StRun;
            end
          end else begin
            mcand_d  = i_a;
            mplier_d = i_b;
            acc_d    = '0;
`ifdef ALU_SEQ_EARLY_EXIT_EN
            if (i_b == 16'd0) begin
              state_d   = StDone;
              result_d  = '0;
              rem_out_d = '0;
            end else begin
              state_d = StRun;
            end
`else
            state_d = StRun;
`endif
          end
        end
      end

      StRun: begin
        cnt_d = cnt_q + 4'd1;
        if (!op_q) begin
          o_alu_opcode = OpcAdd;
          o_alu_wordA  = acc_q;
          o_alu_wordB  = mcand_q;
          acc_d        = acc_new;
          mcand_d      = mcand_q << 1;
          mplier_d     = mplier_shr;
`ifdef ALU_SEQ_EARLY_EXIT_EN
          // Remaining multiplier bits all zero: the accumulator is already final.
          if (mplier_shr == 16'd0) begin
            last_iter = 1'b1;
          end
`endif
          if (last_iter) begin
            state_d   = StDone;
            result_d  = acc_new;
            rem_out_d = '0;
          end
        end else begin
          o_alu_opcode = OpcSub;
          o_alu_wordA  = div_t;
          o_alu_wordB  = divisor_q;
          rem_d        = rem_new;
          quot_d       = quot_new;
          dividend_d   = dividend_q << 1;
          if (last_iter) begin
            state_d   = StDone;
            result_d  = quot_new;
            rem_out_d = rem_new;
          end
        end
      end

      StDone: begin
        state_d = StIdle;
      end

      default: begin
        state_d = StIdle;
      end
    endcase
  end

  assign o_ready  = (state_q == StIdle);
  assign o_busy   = (state_q == StRun) || (state_q == StDone);
  assign o_done   = (state_q == StDone);
  assign o_result = result_q;
  assign o_rem    = rem_out_q;
  assign o_dz     = dz_q;

endmodule

// File: tb/tb_alu_muldiv_seq.sv
// Testbench for alu_muldiv_seq: table of jobs with expected results, scoreboard queue filled
// at accept and drained at o_done, plus hand-written sequences for ignored start and reset abort.

module tb_alu_muldiv_seq;

  logic        i_clk = 1'b0;
  logic        i_rst_n = 1'b0;
  logic        i_start = 1'b0;
  logic        i_op = 1'b0;
  logic [15:0] i_a = '0;
  logic [15:0] i_b = '0;
  logic        o_ready, o_busy, o_done, o_dz;
  logic [15:0] o_result, o_rem;
  logic [3:0]  o_alu_opcode;
  logic [15:0] o_alu_wordA, o_alu_wordB;
  logic [15:0] alu_res;
  logic        alu_carry;

  always #5 i_clk = ~i_clk;

  alu_muldiv_seq dut (
    .i_clk        (i_clk),
    .i_rst_n      (i_rst_n),
    .i_start      (i_start),
    .i_op         (i_op),
    .i_a          (i_a),
    .i_b          (i_b),
    .o_ready      (o_ready),
    .o_busy       (o_busy),
    .o_done       (o_done),
    .o_result     (o_result),
    .o_rem        (o_rem),
    .o_dz         (o_dz),
    .o_alu_opcode (o_alu_opcode),
    .o_alu_wordA  (o_alu_wordA),
    .o_alu_wordB  (o_alu_wordB),
    .i_alu_result (alu_res),
    .i_alu_carry  (alu_carry)
  );

  // Reference combinational ALU: ADD=0, SUB=1 with borrow on carry.
  always_comb begin
    logic [16:0] sum;
    sum       = {1'b0, o_alu_wordA} + {1'b0, o_alu_wordB};
    alu_res   = sum[15:0];
    alu_carry = sum[16];
    if (o_alu_opcode == 4'h1) begin
      alu_res   = o_alu_wordA - o_alu_wordB;
      alu_carry = (o_alu_wordA < o_alu_wordB);
    end
  end

  typedef struct {
    logic        op;
    logic [15:0] a;
    logic [15:0] b;
    logic [15:0] res;
    logic [15:0] rem;
    logic        dz;
  } vec_t;

  typedef struct {
    logic [15:0] res;
    logic [15:0] rem;
    logic        dz;
    int          lat;
    string       name;
  } exp_t;

  exp_t sb[$];
  int   n_pass = 0;
  int   n_total = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h, want %0h", name, act, exp);
  endtask

  function automatic int exp_lat(input logic op, input logic [15:0] b);
    if (op && b == 16'd0) return 1;
`ifdef ALU_SEQ_EARLY_EXIT_EN
    if (!op) begin
      if (b == 16'd0) return 1;
      for (int i = 15; i >= 0; i--) if (b[i]) return i + 2;
    end
`endif
    return 17;
  endfunction

  // Called at a negedge; returns at the negedge of the first cycle after accept.
  task automatic start_job(input string name, input logic op, input logic [15:0] a,
                           input logic [15:0] b, input logic [15:0] res,
                           input logic [15:0] rem, input logic dz);
    exp_t e;
    int   w;
    w = 0;
    while (!o_ready && w < 40) begin
      @(negedge i_clk);
      w++;
    end
    if (!o_ready) check({name, "_ready_wait"}, 32'(o_ready), 32'd1);
    e.res  = res;
    e.rem  = rem;
    e.dz   = dz;
    e.lat  = exp_lat(op, b);
    e.name = name;
    sb.push_back(e);
    i_start = 1'b1;
    i_op    = op;
    i_a     = a;
    i_b     = b;
    @(negedge i_clk);
    i_start = 1'b0;
    i_op    = ~op;
    i_a     = 16'($urandom);
    i_b     = 16'($urandom);
  endtask

  // Optionally pulses i_start in RUN cycle pulse_at; compares against scoreboard head at o_done.
  task automatic wait_done(input int pulse_at);
    exp_t e;
    int   n;
    n = 1;
    while (!o_done && n < 40) begin
      i_start = (n == pulse_at);
      @(negedge i_clk);
      n++;
    end
    i_start = 1'b0;
    if (sb.size() == 0) begin
      check("scoreboard_empty", 32'd1, 32'd0);
      return;
    end
    e = sb.pop_front();
    if (!o_done) begin
      check({e.name, "_done_timeout"}, 32'(o_done), 32'd1);
      return;
    end
    check({e.name, "_latency"}, 32'(n), 32'(e.lat));
    check({e.name, "_result"}, 32'(o_result), 32'(e.res));
    check({e.name, "_rem"}, 32'(o_rem), 32'(e.rem));
    check({e.name, "_dz"}, 32'(o_dz), 32'(e.dz));
    check({e.name, "_busy_ready"}, {30'd0, o_busy, o_ready}, 32'b10);
    check({e.name, "_alu_idle"}, 32'(o_alu_opcode) | 32'(o_alu_wordA) | 32'(o_alu_wordB),
          32'd0);
  endtask

  vec_t vecs[12];

  initial begin
    int dones;
    vecs[0]  = '{1'b0, 16'd3,     16'd5,     16'd15,    16'd0,     1'b0};
    vecs[1]  = '{1'b0, 16'h1234,  16'h0100,  16'h3400,  16'd0,     1'b0};
    vecs[2]  = '{1'b0, 16'hFFFF,  16'hFFFF,  16'h0001,  16'd0,     1'b0};
    vecs[3]  = '{1'b0, 16'h0000,  16'h1234,  16'h0000,  16'd0,     1'b0};
    vecs[4]  = '{1'b0, 16'h00FF,  16'h0101,  16'hFFFF,  16'd0,     1'b0};
    vecs[5]  = '{1'b0, 16'h1234,  16'h0000,  16'h0000,  16'd0,     1'b0};
    vecs[6]  = '{1'b1, 16'd100,   16'd7,     16'd14,    16'd2,     1'b0};
    vecs[7]  = '{1'b1, 16'hFFFF,  16'd1,     16'hFFFF,  16'd0,     1'b0};
    vecs[8]  = '{1'b1, 16'd1234,  16'd0,     16'hFFFF,  16'd1234,  1'b1};
    vecs[9]  = '{1'b1, 16'd7,     16'd100,   16'd0,     16'd7,     1'b0};
    vecs[10] = '{1'b1, 16'hFFFF,  16'hFFFF,  16'd1,     16'd0,     1'b0};
    vecs[11] = '{1'b1, 16'd50000, 16'd300,   16'd166,   16'd200,   1'b0};

    repeat (2) @(negedge i_clk);
    check("rst_ready", 32'(o_ready), 32'd1);
    check("rst_busy", 32'(o_busy), 32'd0);
    check("rst_done", 32'(o_done), 32'd0);
    check("rst_result", 32'(o_result), 32'd0);
    check("rst_rem", 32'(o_rem), 32'd0);
    check("rst_dz", 32'(o_dz), 32'd0);
    check("rst_alu_opcode", 32'(o_alu_opcode), 32'd0);
    check("rst_alu_words", {o_alu_wordA, o_alu_wordB}, 32'd0);
    i_rst_n = 1'b1;
    @(negedge i_clk);

    for (int i = 0; i < 12; i++) begin
      start_job($sformatf("vec%0d", i), vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].res,
                vecs[i].rem, vecs[i].dz);
      wait_done(0);
    end

    // i_start during RUN must be ignored; next job accepted right after DONE.
    start_job("mul_pulse", 1'b0, 16'd3, 16'd5, 16'd15, 16'd0, 1'b0);
    wait_done(2);
    @(negedge i_clk);
    check("post_done_ready", 32'(o_ready), 32'd1);
    check("start_not_queued", 32'(o_done), 32'd0);
    start_job("b2b_div", 1'b1, 16'd100, 16'd7, 16'd14, 16'd2, 1'b0);
    wait_done(0);

    // Reset in RUN cycle 8 aborts the job immediately.
    @(negedge i_clk);
    start_job("rst_job", 1'b0, 16'h00FF, 16'h8001, 16'h80FF, 16'd0, 1'b0);
    repeat (7) @(negedge i_clk);
    check("pre_rst_busy", 32'(o_busy), 32'd1);
    i_rst_n = 1'b0;
    #1;
    check("abort_ready", 32'(o_ready), 32'd1);
    check("abort_busy_done", {o_busy, o_done}, 32'd0);
    check("abort_result", 32'(o_result), 32'd0);
    check("abort_rem_dz", {o_rem, o_dz}, 32'd0);
    check("abort_alu", 32'(o_alu_opcode) | 32'(o_alu_wordA) | 32'(o_alu_wordB), 32'd0);
    sb.delete();
    @(negedge i_clk);
    i_rst_n = 1'b1;
    dones = 0;
    for (int i = 0; i < 25; i++) begin
      @(negedge i_clk);
      if (o_done) dones++;
    end
    check("no_done_after_reset", 32'(dones), 32'd0);
    start_job("post_rst_mul", 1'b0, 16'd3, 16'd7, 16'd21, 16'd0, 1'b0);
    wait_done(0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
